uart_rdata_hexfmt: RTL and testbench

- Downstream consumer of the monitor's memory-dump/PC-print logic.
- On a send-start pulse, latches the 64-bit read-data word (or 32-bit PC value) and serialises it as uppercase ASCII hex plus end-of-line into the UART transmit byte stream over a valid/ready handshake.
- When the last byte has been accepted, pulses flushing_wq so the dump sequencer advances to the next word pair or returns to idle.

---
 rtl/uart_rdata_hexfmt.sv | 147 ++++++++++++++
 tb/tb_uart_rdata_hexfmt.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rdata_hexfmt.sv
// Formats a latched 64-bit read-data word (or 32-bit PC) as uppercase ASCII hex
// plus end-of-line, and hands it byte by byte to a UART transmitter over valid/ready.
module uart_rdata_hexfmt #(
    parameter bit         EOL_CRLF = 1'b1,
    parameter logic [7:0] SEP_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdata_snd_start,
    input  logic [63:0] rdata_snd,
    input  logic        pc_print_sel,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        flushing_wq,
    output logic        fmt_busy,
    output logic        start_drop
);

    typedef enum logic [2:0] {IDLE, HEX, SEP, EOL_CR, EOL_LF, DONE} state_t;

    localparam state_t     EOL_START = EOL_CRLF ? EOL_CR : EOL_LF;
    localparam logic [7:0] EOL_BYTE  = EOL_CRLF ? 8'h0D : 8'h0A;

    state_t      state_q, state_d;
    logic [63:0] shadow_q, shadow_d;
    logic        pc_mode_q, pc_mode_d;
    logic [3:0]  nib_q, nib_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        flushing_q, flushing_d;
    logic        start_drop_q, start_drop_d;
    logic        accept;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Counter bit 3 picks the word; low bits walk that word MS nibble first.
    function automatic logic [3:0] nibble_at(input logic [63:0] w, input logic [3:0] idx);
        logic [5:0] sh;
        sh = {idx[3], ~idx[2:0], 2'b00};
        return w[sh +: 4];
    endfunction

    assign accept = tx_valid_q & tx_ready;

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        pc_mode_d    = pc_mode_q;
        nib_d        = nib_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        flushing_d   = 1'b0;
        start_drop_d = start_drop_q;

        if (rdata_snd_start) begin
            start_drop_d = (state_q != IDLE);
        end

        case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (rdata_snd_start) begin
                    shadow_d   = rdata_snd;
                    pc_mode_d  = pc_print_sel;
                    nib_d      = 4'd0;
                    state_d    = HEX;
                    tx_valid_d = 1'b1;
                    tx_data_d  = hex_ascii(rdata_snd[31:28]);
                end
            end
            HEX: begin
                if (accept) begin
                    if (nib_q == 4'd15 || (nib_q == 4'd7 && pc_mode_q)) begin
                        state_d   = EOL_START;
                        tx_data_d = EOL_BYTE;
                    end else if (nib_q == 4'd7) begin
                        state_d   = SEP;
                        tx_data_d = SEP_CHAR;
                    end else begin
                        nib_d     = nib_q + 4'd1;
                        tx_data_d = hex_ascii(nibble_at(shadow_q, nib_q + 4'd1));
                    end
                end
            end
            SEP: begin
                if (accept) begin
                    state_d   = HEX;
                    nib_d     = 4'd8;
                    tx_data_d = hex_ascii(shadow_q[63:60]);
                end
            end
            EOL_CR: begin
                if (accept) begin
                    state_d   = EOL_LF;
                    tx_data_d = 8'h0A;
                end
            end
            EOL_LF: begin
                if (accept) begin
                    state_d    = DONE;
                    tx_valid_d = 1'b0;
                    flushing_d = 1'b1;
                end
            end
            DONE: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shadow_q     <= 64'h0;
            pc_mode_q    <= 1'b0;
            nib_q        <= 4'd0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            flushing_q   <= 1'b0;
            start_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            pc_mode_q    <= pc_mode_d;
            nib_q        <= nib_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            flushing_q   <= flushing_d;
            start_drop_q <= start_drop_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign flushing_wq = flushing_q;
    assign fmt_busy    = (state_q != IDLE);
    assign start_drop  = start_drop_q;

endmodule

// File: tb/tb_uart_rdata_hexfmt.sv
// Bench for uart_rdata_hexfmt: a CRLF build and an LF-only build run side by side
// on shared stimulus; captured byte streams are compared with a string-level model.
module tb_uart_rdata_hexfmt;

    logic        clk;
    logic        rst_n;
    logic        rdata_snd_start;
    logic [63:0] rdata_snd;
    logic        pc_print_sel;
    logic        tx_ready;

    logic [7:0]  tx_data0, tx_data1;
    logic        tx_valid0, tx_valid1;
    logic        flush0, flush1;
    logic        busy0, busy1;
    logic        drop0, drop1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int fl0, fl1, flc0, flc1, fa0, fa1;
    logic       pv0, pv1, pr0, pr1;
    logic [7:0] pd0, pd1;

    uart_rdata_hexfmt #(.EOL_CRLF(1'b1), .SEP_CHAR(8'h20)) dut (
        .clk(clk), .rst_n(rst_n), .rdata_snd_start(rdata_snd_start), .rdata_snd(rdata_snd),
        .pc_print_sel(pc_print_sel), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready), .flushing_wq(flush0), .fmt_busy(busy0), .start_drop(drop0)
    );

    uart_rdata_hexfmt #(.EOL_CRLF(1'b0), .SEP_CHAR(8'h20)) dut_lf (
        .clk(clk), .rst_n(rst_n), .rdata_snd_start(rdata_snd_start), .rdata_snd(rdata_snd),
        .pc_print_sel(pc_print_sel), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready), .flushing_wq(flush1), .fmt_busy(busy1), .start_drop(drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the line as text, built from the hex rules directly.
    function automatic string model(input logic [63:0] d, input bit pc, input bit crlf);
        string s;
        logic [31:0] w;
        int n;
        s = "";
        for (int k = 0; k < (pc ? 1 : 2); k++) begin
            w = (k == 0) ? d[31:0] : d[63:32];
            if (k == 1) s = {s, " "};
            for (int i = 7; i >= 0; i--) begin
                n = (w >> (4 * i)) & 15;
                s = $sformatf("%s%c", s, (n < 10) ? (8'd48 + 8'(n)) : (8'd55 + 8'(n)));
            end
        end
        if (crlf) s = {s, "\r\n"};
        else      s = {s, "\n"};
        return s;
    endfunction

    function automatic string hexs(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++) r = $sformatf("%s%02x", r, s[i]);
        return r;
    endfunction

    function automatic string q_to_s(input logic [7:0] q[$]);
        string r;
        r = "";
        foreach (q[i]) r = $sformatf("%s%c", r, q[i]);
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got bytes %s, expected %s", name, hexs(act), hexs(exp));
        end
    endtask

    // Byte capture, flush capture and stall-stability checking.
    always @(negedge clk) begin
        if (!rst_n) begin
            pv0 = 1'b0;
            pv1 = 1'b0;
        end else begin
            if (pv0 && !pr0) begin
                n_chk++;
                if (!(tx_valid0 && tx_data0 == pd0)) begin
                    n_fail++;
                    $display("FAIL stall_hold_crlf: valid=%0d data=%02x, expected valid=1 data=%02x", tx_valid0, tx_data0, pd0);
                end
            end
            if (pv1 && !pr1) begin
                n_chk++;
                if (!(tx_valid1 && tx_data1 == pd1)) begin
                    n_fail++;
                    $display("FAIL stall_hold_lf: valid=%0d data=%02x, expected valid=1 data=%02x", tx_valid1, tx_data1, pd1);
                end
            end
            if (tx_valid0 && tx_ready) begin
                if (q0.size() == 0) fa0 = cyc;
                q0.push_back(tx_data0);
            end
            if (tx_valid1 && tx_ready) begin
                if (q1.size() == 0) fa1 = cyc;
                q1.push_back(tx_data1);
            end
            if (flush0) begin
                if (fl0 == 0) flc0 = cyc;
                fl0++;
            end
            if (flush1) begin
                if (fl1 == 0) flc1 = cyc;
                fl1++;
            end
            pv0 = tx_valid0; pr0 = tx_ready; pd0 = tx_data0;
            pv1 = tx_valid1; pr1 = tx_ready; pd1 = tx_data1;
        end
    end

    task automatic run_line(input logic [63:0] d, input bit pc, input bit bp,
                            input string exp0, input int inject);
        string exp1;
        int st_cyc, stall;
        bit timed_out;
        exp1 = model(d, pc, 1'b0);
        q0.delete(); q1.delete();
        fl0 = 0; fl1 = 0; stall = 0;
        @(posedge clk); #1;
        rdata_snd = d; pc_print_sel = pc; rdata_snd_start = 1'b1; tx_ready = 1'b1;
        st_cyc = cyc;
        @(posedge clk); #1;
        rdata_snd_start = 1'b0;
        rdata_snd = {$urandom, $urandom};
        pc_print_sel = 1'($urandom);
        timed_out = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (fl0 > 0 && fl1 > 0) begin
                timed_out = 1'b0;
                break;
            end
            if (bp) begin
                if (stall > 0) begin
                    tx_ready = 1'b0;
                    stall--;
                end else begin
                    tx_ready = 1'b1;
                    stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
                end
            end
            if (inject != 0 && c == inject) begin
                rdata_snd = 64'hDEADBEEF_CAFEF00D;
                pc_print_sel = 1'b0;
                rdata_snd_start = 1'b1;
            end else begin
                rdata_snd_start = 1'b0;
            end
            @(posedge clk); #1;
        end
        rdata_snd_start = 1'b0;
        tx_ready = 1'b1;
        chk("line_timeout", timed_out, 0);
        repeat (3) @(posedge clk);
        #1;
        chk_str("bytes_crlf", q_to_s(q0), exp0);
        chk_str("bytes_lf", q_to_s(q1), exp1);
        chk("flush_count_crlf", fl0, 1);
        chk("flush_count_lf", fl1, 1);
        chk("busy_after_crlf", busy0, 0);
        chk("valid_after_lf", tx_valid1, 0);
        if (!bp) begin
            chk("first_byte_latency", fa0 - st_cyc, 1);
            chk("flush_latency_crlf", flc0 - st_cyc, exp0.len() + 1);
            chk("flush_latency_lf", flc1 - st_cyc, exp1.len() + 1);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        bit          pc;
        bit          bp;
        string       exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [63:0] d;
        bit          pc, bp;
        bit          to;

        vecs[0] = '{64'h89ABCDEF_01234567, 1'b0, 1'b0, "01234567 89ABCDEF\r\n"};
        vecs[1] = '{{32'hFFFF_FFFF, 32'h0000_1A2C}, 1'b1, 1'b0, "00001A2C\r\n"};
        vecs[2] = '{64'h89ABCDEF_01234567, 1'b0, 1'b1, "01234567 89ABCDEF\r\n"};
        vecs[3] = '{64'h0, 1'b0, 1'b0, "00000000 00000000\r\n"};
        vecs[4] = '{64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b1, "FFFFFFFF FFFFFFFF\r\n"};
        vecs[5] = '{64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0, "FFFFFFFF\r\n"};

        rst_n = 1'b0; rdata_snd_start = 1'b0; rdata_snd = 64'h0; pc_print_sel = 1'b0; tx_ready = 1'b1;
        fl0 = 0; fl1 = 0; flc0 = 0; flc1 = 0; fa0 = 0; fa1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_data", tx_data0, 8'h00);
        chk("rst_tx_valid", tx_valid0, 0);
        chk("rst_flush", flush0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_drop", drop0, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) run_line(vecs[i].data, vecs[i].pc, vecs[i].bp, vecs[i].exp, 0);

        for (int i = 0; i < 8; i++) begin
            d  = {$urandom, $urandom};
            pc = 1'($urandom_range(0, 1));
            bp = 1'($urandom_range(0, 1));
            run_line(d, pc, bp, model(d, pc, 1'b1), 0);
        end
        chk("drop_clear_normal", drop0, 0);

        // Start issued mid-line is dropped; the next legal start clears the flag.
        run_line(64'h89ABCDEF_01234567, 1'b0, 1'b0, "01234567 89ABCDEF\r\n", 5);
        chk("drop_set_crlf", drop0, 1);
        chk("drop_set_lf", drop1, 1);
        run_line(64'hDEADBEEF_CAFEF00D, 1'b0, 1'b0, "CAFEF00D DEADBEEF\r\n", 0);
        chk("drop_cleared_crlf", drop0, 0);
        chk("drop_cleared_lf", drop1, 0);

        // Reset after five bytes abandons the line without a flush.
        q0.delete(); q1.delete(); fl0 = 0; fl1 = 0;
        @(posedge clk); #1;
        rdata_snd = 64'h89ABCDEF_01234567; pc_print_sel = 1'b0; rdata_snd_start = 1'b1;
        @(posedge clk); #1;
        rdata_snd_start = 1'b0;
        to = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (q0.size() >= 5) begin
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rst_wait_timeout", to, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", tx_valid0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_busy_lf", busy1, 0);
        chk("midrst_data", tx_data0, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("midrst_no_flush", fl0 + fl1, 0);
        chk("midrst_idle_valid", tx_valid0, 0);
        run_line(64'h13579BDF_2468ACE0, 1'b0, 1'b0, "2468ACE0 13579BDF\r\n", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
